seq_detector_param: RTL and testbench



---
 rtl/seq_detector_param.sv | 95 +++++++++
 tb/tb_seq_detector_param.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/seq_detector_param.sv
// Parametrised Moore sequence detector with run-time overlap selection.
// Optional saturating match counter is built only when SEQ_DET_COUNT_EN is defined.
module seq_detector_param #(
   parameter int           N       = 5,
   parameter logic [N-1:0] PATTERN = 5'b10011,
   parameter int           CW      = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          data,
   input  logic          valid,
   input  logic          overlap,
   output logic          detected,
   output logic [CW-1:0] match_count
);
   localparam int            SW     = $clog2(N + 1);
   localparam logic [SW-1:0] S_FULL = SW'(N);

   logic [SW-1:0] s_r;
   logic [N-2:0]  hist_r;
   logic          det_r;
   logic [N-1:0]  win_s;
   logic [N-1:0]  pre_s;
   logic [N-1:0]  mask_s;
   logic [SW-1:0] lim_s;
   logic [SW-1:0] best_s;
   logic [SW-1:0] nxt_s;

   // Next state: longest pattern prefix ending at the new bit, searched only
   // within the last s+1 bits so stale history never produces a false match.
   always_comb begin
      win_s  = {hist_r, data};
      best_s = {SW{1'b0}};
      pre_s  = {N{1'b0}};
      mask_s = {N{1'b0}};
      if (s_r == S_FULL) begin
         lim_s = S_FULL;
      end else begin
         lim_s = s_r + SW'(1);
      end
      for (int k = 1; k <= N; k++) begin
         pre_s  = PATTERN >> (N - k);
         mask_s = {N{1'b1}} >> (N - k);
         if ((k <= int'(lim_s)) && (((win_s ^ pre_s) & mask_s) == {N{1'b0}})) begin
            best_s = SW'(k);
         end else begin
            best_s = best_s;
         end
      end
      if ((s_r == S_FULL) && !overlap) begin
         nxt_s = {{(SW-1){1'b0}}, (data == PATTERN[N-1])};
      end else begin
         nxt_s = best_s;
      end
   end

   // State, bit history and registered detect flag; updated only on accepted bits.
   always_ff @(posedge clk) begin
      if (!rst) begin
         s_r    <= {SW{1'b0}};
         hist_r <= {(N-1){1'b0}};
         det_r  <= 1'b0;
      end else if (valid) begin
         s_r    <= nxt_s;
         hist_r <= win_s[N-2:0];
         det_r  <= (nxt_s == S_FULL);
      end else begin
         s_r    <= s_r;
         hist_r <= hist_r;
         det_r  <= det_r;
      end
   end

   assign detected = det_r;

`ifdef SEQ_DET_COUNT_EN
   logic [CW-1:0] cnt_r;

   // Saturating count of completed matches.
   always_ff @(posedge clk) begin
      if (!rst) begin
         cnt_r <= {CW{1'b0}};
      end else if (valid && (nxt_s == S_FULL) && (cnt_r != {CW{1'b1}})) begin
         cnt_r <= cnt_r + CW'(1);
      end else begin
         cnt_r <= cnt_r;
      end
   end

   assign match_count = cnt_r;
`else
   assign match_count = {CW{1'b0}};
`endif

endmodule

// File: tb/tb_seq_detector_param.sv
// Randomised and directed bench for seq_detector_param; three parameter sets share one
// stimulus stream and are checked every cycle against a stream-based reference model.
module tb_seq_detector_param;
`ifdef SEQ_DET_COUNT_EN
   localparam bit CNT_EN = 1'b1;
`else
   localparam bit CNT_EN = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       data = 1'b0;
   logic       valid = 1'b0;
   logic       overlap = 1'b0;
   logic       det0, det1, det2;
   logic [7:0] mc0, mc1;
   logic [1:0] mc2;

   int errors = 0;
   int checks = 0;
   bit chk_on = 1'b0;

   int          m_n[3];
   logic [15:0] m_pat[3];
   int          m_max[3];
   logic [31:0] m_h[3];
   int          m_len[3];
   int          m_s[3];
   int          m_cnt[3];

   always #5 clk = ~clk;

   seq_detector_param u0 (
      .clk(clk), .rst(rst), .data(data), .valid(valid), .overlap(overlap),
      .detected(det0), .match_count(mc0));
   seq_detector_param #(.N(4), .PATTERN(4'b1111), .CW(8)) u1 (
      .clk(clk), .rst(rst), .data(data), .valid(valid), .overlap(overlap),
      .detected(det1), .match_count(mc1));
   seq_detector_param #(.N(2), .PATTERN(2'b11), .CW(2)) u2 (
      .clk(clk), .rst(rst), .data(data), .valid(valid), .overlap(overlap),
      .detected(det2), .match_count(mc2));

   // Longest suffix of the accepted stream (h[0] newest) equal to a pattern prefix.
   function automatic int longest(logic [31:0] h, int len, int n, logic [15:0] p);
      bit ok;
      for (int k = n; k >= 1; k--) begin
         if (k <= len) begin
            ok = 1'b1;
            for (int i = 0; i < k; i++) begin
               if (h[i] != p[n-k+i]) ok = 1'b0;
            end
            if (ok) return k;
         end
      end
      return 0;
   endfunction

   task automatic model_step(input int i, input logic r, input logic v, input logic d,
                             input logic o);
      if (!r) begin
         m_h[i] = '0; m_len[i] = 0; m_s[i] = 0; m_cnt[i] = 0;
      end else if (v) begin
         if (m_s[i] == m_n[i] && !o) begin
            m_h[i] = '0; m_len[i] = 0;
         end
         m_h[i] = {m_h[i][30:0], d};
         if (m_len[i] < 32) m_len[i]++;
         m_s[i] = longest(m_h[i], m_len[i], m_n[i], m_pat[i]);
         if (m_s[i] == m_n[i] && m_cnt[i] < m_max[i]) m_cnt[i]++;
      end
   endtask

   task automatic acc(input logic r, input logic v, input logic d, input logic o);
      @(negedge clk);
      rst = r; valid = v; data = d; overlap = o;
      for (int i = 0; i < 3; i++) model_step(i, r, v, d, o);
      chk_on = 1'b1;
   endtask

   task automatic settle();
      @(posedge clk);
      #2;
   endtask

   task automatic lit(input string name, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, got, exp);
      end
   endtask

   // Per-cycle comparison of every instance against the model.
   always @(posedge clk) begin
      int gd[3];
      int gc[3];
      #1;
      if (chk_on) begin
         gd[0] = int'(det0); gd[1] = int'(det1); gd[2] = int'(det2);
         gc[0] = int'(mc0);  gc[1] = int'(mc1);  gc[2] = int'(mc2);
         for (int i = 0; i < 3; i++) begin
            checks += 2;
            if (gd[i] != int'(m_s[i] == m_n[i])) begin
               errors++;
               $display("FAIL detected inst%0d t=%0t: got %0d expected %0d", i, $time,
                        gd[i], int'(m_s[i] == m_n[i]));
            end
            if (gc[i] != (CNT_EN ? m_cnt[i] : 0)) begin
               errors++;
               $display("FAIL match_count inst%0d t=%0t: got %0d expected %0d", i, $time,
                        gc[i], CNT_EN ? m_cnt[i] : 0);
            end
         end
      end
   end

   initial begin
      logic [8:0] seq_a;
      logic [4:0] seq_b;
      logic       o;
      m_n[0] = 5; m_pat[0] = 16'h0013; m_max[0] = 255;
      m_n[1] = 4; m_pat[1] = 16'h000F; m_max[1] = 255;
      m_n[2] = 2; m_pat[2] = 16'h0003; m_max[2] = 3;
      for (int i = 0; i < 3; i++) begin
         m_h[i] = '0; m_len[i] = 0; m_s[i] = 0; m_cnt[i] = 0;
      end
      seq_a = 9'b100110011;
      seq_b = 5'b10011;

      acc(1'b0, 1'b1, 1'b1, 1'b1);
      settle();
      lit("reset_det", int'(det0), 0);
      lit("reset_cnt", int'(mc0), 0);

      // Overlapping, default pattern
      for (int b = 8; b >= 0; b--) begin
         acc(1'b1, 1'b1, seq_a[b], 1'b1);
         settle();
         if (b == 4) lit("ovl_bit5_det", int'(det0), 1);
         if (b == 3) lit("ovl_bit6_det", int'(det0), 0);
      end
      lit("ovl_bit9_det", int'(det0), 1);
      lit("ovl_cnt", int'(mc0), CNT_EN ? 2 : 0);
      acc(1'b0, 1'b0, 1'b0, 1'b0);

      // Non-overlapping, same stream
      for (int b = 8; b >= 0; b--) begin
         acc(1'b1, 1'b1, seq_a[b], 1'b0);
         settle();
         if (b == 4) lit("novl_bit5_det", int'(det0), 1);
      end
      lit("novl_bit9_det", int'(det0), 0);
      lit("novl_cnt", int'(mc0), CNT_EN ? 1 : 0);
      acc(1'b0, 1'b0, 1'b0, 1'b0);

      // Seven ones, overlapping
      for (int b = 1; b <= 7; b++) begin
         acc(1'b1, 1'b1, 1'b1, 1'b1);
         settle();
         if (b >= 4) lit("ones_ovl_det", int'(det1), 1);
      end
      lit("ones_ovl_cnt", int'(mc1), CNT_EN ? 4 : 0);
      lit("sat_cnt", int'(mc2), CNT_EN ? 3 : 0);
      acc(1'b0, 1'b0, 1'b0, 1'b0);

      // Seven ones, non-overlapping
      for (int b = 1; b <= 7; b++) begin
         acc(1'b1, 1'b1, 1'b1, 1'b0);
         settle();
         if (b == 4) lit("ones_novl_bit4", int'(det1), 1);
         if (b == 5) lit("ones_novl_bit5", int'(det1), 0);
      end
      lit("ones_novl_cnt", int'(mc1), CNT_EN ? 1 : 0);
      acc(1'b0, 1'b0, 1'b0, 1'b0);

      // Valid gaps with random data on idle cycles
      for (int b = 4; b >= 0; b--) begin
         acc(1'b1, 1'b1, seq_b[b], 1'b1);
         for (int g = 0; g < 3; g++) acc(1'b1, 1'b0, 1'($urandom_range(0, 1)), 1'b1);
      end
      settle();
      lit("gap_hold_det", int'(det0), 1);
      acc(1'b1, 1'b1, 1'b0, 1'b1);
      settle();
      lit("gap_fall_det", int'(det0), 0);
      acc(1'b0, 1'b0, 1'b0, 1'b0);

      // Reset mid-match
      for (int b = 4; b >= 1; b--) acc(1'b1, 1'b1, seq_b[b], 1'b1);
      acc(1'b0, 1'b1, 1'b1, 1'b1);
      acc(1'b1, 1'b1, 1'b1, 1'b1);
      settle();
      lit("midrst_det", int'(det0), 0);
      lit("midrst_cnt", int'(mc0), 0);

      // Random traffic
      o = 1'b1;
      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(0, 19) == 0) o = ~o;
         acc(1'($urandom_range(0, 149) != 0), 1'($urandom_range(0, 3) != 0),
             1'($urandom_range(0, 1)), o);
      end
      settle();
      chk_on = 1'b0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
